// File: rtl/wishbone_pkg.sv
// Shared types and helpers for the Wishbone RAM slave and its byte-lane RAM.
package wishbone_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_slave_state_t;
    typedef enum logic [1:0] {RESP_OK, RESP_ERR, RESP_RTY} wb_resp_t;

    // Computed in 33 bits so a window ending at the top of the address map cannot wrap.
    function automatic logic wb_in_window(input logic [31:0] adr,
                                          input logic [31:0] base,
                                          input int unsigned depth);
        logic [32:0] off;
        logic [32:0] limit;
        off   = {1'b0, adr} - {1'b0, base};
        limit = {1'b0, depth} << 2;
        return (adr >= base) && (off < limit);
    endfunction

endpackage

// File: rtl/wishbone_be_ram.sv
// Single-port synchronous RAM, one array per byte lane, write-first registered read.
module wishbone_be_ram
    import wishbone_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic                           we,
    input  logic [WB_SEL_W-1:0]            be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WB_DATA_W-1:0]           wdata,
    output logic [WB_DATA_W-1:0]           rdata
);

    generate
        for (genvar gi = 0; gi < WB_SEL_W; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_reg;

            always_ff @(posedge clk_i) begin
                if (we && be[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                    rd_reg    <= wdata[8*gi +: 8];
                end else begin
                    rd_reg    <= mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/wishbone_ram_slave.sv
// Wishbone classic slave backing a word-addressed RAM window with wait states,
// error on bad address and retry while the local hold is active.
module wishbone_ram_slave
    import wishbone_pkg::*;
#(
    parameter int unsigned TAGSIZE     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          adr_i,
    input  logic [31:0]          dat_i,
    input  logic [TAGSIZE-1:0]   tgd_i,
    input  logic [TAGSIZE-1:0]   tga_i,
    input  logic [TAGSIZE-1:0]   tgc_i,
    input  logic [3:0]           sel_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic                 hold_i,
    output logic [31:0]          dat_o,
    output logic [TAGSIZE-1:0]   tgd_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic                 rty_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    wb_slave_state_t       state_reg;
    logic [3:0]            cnt_reg;
    logic                  we_reg;
    logic [WB_SEL_W-1:0]   sel_reg;
    logic [WB_DATA_W-1:0]  dat_reg;
    logic [AW-1:0]         idx_reg;
    logic [TAGSIZE-1:0]    tgc_reg;
    logic                  rd_resp_reg;

    logic                  req;
    logic [31:0]           off_in;
    logic [AW-1:0]         idx_in;
    wb_resp_t              kind_in;

    logic                  ram_we;
    logic [WB_SEL_W-1:0]   ram_be;
    logic [AW-1:0]         ram_addr;
    logic [WB_DATA_W-1:0]  ram_wdata;
    logic [WB_DATA_W-1:0]  ram_rdata;

    logic                  unused_ok;

    assign req    = cyc_i & stb_i;
    assign off_in = adr_i - BASE_ADDR;
    assign idx_in = off_in[AW+1:2];

    always_comb begin
        kind_in = RESP_OK;
        if (hold_i)
            kind_in = RESP_RTY;
        else if (adr_i[1:0] != 2'b00)
            kind_in = RESP_ERR;
        else if (!wb_in_window(adr_i, BASE_ADDR, DEPTH_WORDS))
            kind_in = RESP_ERR;
    end

    // The RAM write lands on the edge that enters RESP; the address presented in
    // that same cycle also feeds the registered read used during RESP.
    always_comb begin
        ram_addr  = idx_reg;
        ram_be    = sel_reg;
        ram_wdata = dat_reg;
        ram_we    = 1'b0;
        case (state_reg)
            IDLE: begin
                ram_addr  = idx_in;
                ram_be    = sel_i;
                ram_wdata = dat_i;
                ram_we    = req && (kind_in == RESP_OK) && we_i && (WAIT_STATES == 0);
            end
            WAIT: begin
                ram_we    = cyc_i && (cnt_reg == '0) && we_reg;
            end
            default: ;
        endcase
        if (rst_i)
            ram_we = 1'b0;
    end

    wishbone_be_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            rty_o       <= 1'b0;
            tgd_o       <= '0;
            rd_resp_reg <= 1'b0;
        end else begin
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            rty_o       <= 1'b0;
            tgd_o       <= '0;
            rd_resp_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        we_reg  <= we_i;
                        sel_reg <= sel_i;
                        dat_reg <= dat_i;
                        idx_reg <= idx_in;
                        tgc_reg <= tgc_i;
                        if ((kind_in == RESP_OK) && (WAIT_STATES > 0)) begin
                            state_reg <= WAIT;
                            cnt_reg   <= 4'(WAIT_STATES - 1);
                        end else begin
                            state_reg   <= RESP;
                            ack_o       <= (kind_in == RESP_OK);
                            err_o       <= (kind_in == RESP_ERR);
                            rty_o       <= (kind_in == RESP_RTY);
                            tgd_o       <= (kind_in == RESP_OK) ? tgc_i : '0;
                            rd_resp_reg <= (kind_in == RESP_OK) && !we_i;
                        end
                    end
                end
                WAIT: begin
                    if (!cyc_i) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == '0) begin
                        state_reg   <= RESP;
                        ack_o       <= 1'b1;
                        tgd_o       <= tgc_reg;
                        rd_resp_reg <= !we_reg;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dat_o = rd_resp_reg ? ram_rdata : '0;

    assign unused_ok = ^{tgd_i, tga_i, off_in};

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Randomised scoreboard bench for wishbone_ram_slave against a word-array reference model.
module tb_wishbone_ram_slave;

    localparam int          TS    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 16;
    localparam int          WS    = 3;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [31:0]   adr_i = '0;
    logic [31:0]   dat_i = '0;
    logic [TS-1:0] tgd_i = '0;
    logic [TS-1:0] tga_i = '0;
    logic [TS-1:0] tgc_i = '0;
    logic [3:0]    sel_i = '0;
    logic          cyc_i = 1'b0;
    logic          stb_i = 1'b0;
    logic          we_i = 1'b0;
    logic          hold_i = 1'b0;
    logic [31:0]   dat_o;
    logic [TS-1:0] tgd_o;
    logic          ack_o, err_o, rty_o;

    wishbone_ram_slave #(
        .TAGSIZE(TS), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i),
        .tgd_i(tgd_i), .tga_i(tga_i), .tgc_i(tgc_i), .sel_i(sel_i),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .hold_i(hold_i),
        .dat_o(dat_o), .tgd_o(tgd_o), .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int            kind;     // 0 ack, 1 err, 2 rty
        logic [31:0]   dat;
        logic [TS-1:0] tgd;
        bit            chk_dat;
        int            cyc;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model [DEPTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    function automatic int calc_kind(input logic [31:0] adr, input bit hold);
        if (hold) return 2;
        if (adr[1:0] != 2'b00) return 1;
        if (longint'(adr) < longint'(BASE)) return 1;
        if (longint'(adr) >= longint'(BASE) + 4 * DEPTH) return 1;
        return 0;
    endfunction

    task automatic drive_idle();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; hold_i = 1'b0;
        adr_i = '0; dat_i = '0; sel_i = '0; tgc_i = '0;
    endtask

    task automatic do_req(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input bit we, input logic [TS-1:0] tgc, input bit hold);
        exp_t e;
        int   idx;
        @(negedge clk);
        adr_i = adr; dat_i = dat; sel_i = sel; we_i = we; tgc_i = tgc; hold_i = hold;
        cyc_i = 1'b1; stb_i = 1'b1;
        tgd_i = TS'($urandom); tga_i = TS'($urandom);
        e.kind = calc_kind(adr, hold);
        e.cyc  = cyc_cnt + 1 + ((e.kind == 0) ? WS : 0);
        e.dat = '0; e.tgd = '0; e.chk_dat = 1'b1;
        if (e.kind == 0) begin
            idx   = int'((adr - BASE) >> 2);
            e.tgd = tgc;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) model[idx][8*b +: 8] = dat[8*b +: 8];
                e.chk_dat = 1'b0;
            end else begin
                e.dat = model[idx];
            end
        end
        q.push_back(e);
        while (cyc_cnt < e.cyc) begin
            @(negedge clk);
            hold_i = 1'($urandom);  // hold is irrelevant once the request is captured
        end
        drive_idle();
    endtask

    task automatic do_b2b(input logic [31:0] adr, input int n, input logic [TS-1:0] tgc);
        exp_t e;
        int   t;
        @(negedge clk);
        adr_i = adr; sel_i = 4'h3; we_i = 1'b0; tgc_i = tgc; hold_i = 1'b0;
        cyc_i = 1'b1; stb_i = 1'b1;
        t = cyc_cnt + 1;
        for (int i = 0; i < n; i++) begin
            e.kind = 0; e.dat = model[int'((adr - BASE) >> 2)]; e.tgd = tgc;
            e.chk_dat = 1'b1; e.cyc = t + i * (WS + 2) + WS;
            q.push_back(e);
        end
        while (cyc_cnt < e.cyc) @(negedge clk);
        drive_idle();
    endtask

    task automatic do_abort(input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        adr_i = adr; dat_i = dat; sel_i = 4'hF; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        @(negedge clk);
        drive_idle();
        repeat (WS + 3) @(negedge clk);
    endtask

    task automatic do_reset_mid(input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        adr_i = adr; dat_i = dat; sel_i = 4'hF; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", ack_o, 0);
        check("rst_mid_err", err_o, 0);
        check("rst_mid_rty", rty_o, 0);
        check("rst_mid_dat", dat_o, 0);
        check("rst_mid_tgd", tgd_o, 0);
        rst_i = 1'b0;
        drive_idle();
        repeat (WS + 3) @(negedge clk);
    endtask

    // Monitor: every termination pops the scoreboard; quiet cycles must drive zeros.
    initial begin : monitor
        bit       prev_term = 1'b0;
        logic [2:0] term;
        exp_t     e;
        int       act_kind;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                term = {rty_o, err_o, ack_o};
                if (term != 3'b000) begin
                    check("term_onehot", $countones(term), 1);
                    check("term_consecutive", prev_term, 0);
                    act_kind = ack_o ? 0 : (err_o ? 1 : 2);
                    if (q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_term: got kind %0d expected none (cycle %0d)", act_kind, cyc_cnt);
                    end else begin
                        e = q.pop_front();
                        check("term_kind", act_kind, e.kind);
                        check("term_cycle", cyc_cnt, e.cyc);
                        check("resp_tgd", tgd_o, e.tgd);
                        if (e.chk_dat) check("resp_dat", dat_o, e.dat);
                    end
                end else begin
                    check("quiet_dat", dat_o, 0);
                    check("quiet_tgd", tgd_o, 0);
                end
                prev_term = (term != 3'b000);
            end else begin
                prev_term = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d responses outstanding", q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] a;
        repeat (3) @(negedge clk);
        check("reset_ack", ack_o, 0);
        check("reset_err", err_o, 0);
        check("reset_rty", rty_o, 0);
        check("reset_dat", dat_o, 0);
        check("reset_tgd", tgd_o, 0);
        rst_i = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            do_req(BASE + 32'(4 * i), $urandom, 4'hF, 1'b1, TS'(i), 1'b0);

        do_req(BASE + 32'h8, 32'hDEADBEEF, 4'hF, 1'b1, 2'd1, 1'b0);
        do_req(BASE + 32'h8, 32'h0, 4'hF, 1'b0, 2'd2, 1'b0);
        do_req(BASE + 32'h8, 32'h11223344, 4'b0101, 1'b1, 2'd3, 1'b0);
        do_req(BASE + 32'h8, 32'h0, 4'h1, 1'b0, 2'd1, 1'b0);

        do_req(BASE + 32'h2, 32'h55555555, 4'hF, 1'b1, 2'd2, 1'b0);
        do_req(BASE + 32'(4 * DEPTH), 32'h66666666, 4'hF, 1'b1, 2'd3, 1'b0);
        do_req(BASE - 32'h4, 32'h77777777, 4'hF, 1'b1, 2'd1, 1'b0);
        do_req(BASE + 32'(4 * DEPTH - 4), 32'hA5A5_5A5A, 4'hF, 1'b1, 2'd2, 1'b0);
        do_req(BASE + 32'(4 * DEPTH - 4), 32'h0, 4'hF, 1'b0, 2'd3, 1'b0);

        do_req(BASE + 32'h8, 32'hBAD0BAD0, 4'hF, 1'b1, 2'd1, 1'b1);
        do_req(BASE + 32'h8, 32'h0, 4'hF, 1'b0, 2'd2, 1'b0);
        do_req(BASE + 32'h8, 32'hFFFFFFFF, 4'h0, 1'b1, 2'd3, 1'b0);
        do_req(BASE + 32'h8, 32'h0, 4'hF, 1'b0, 2'd1, 1'b0);

        do_abort(BASE + 32'h8, 32'hCAFEF00D);
        do_req(BASE + 32'h8, 32'h0, 4'hF, 1'b0, 2'd2, 1'b0);
        do_reset_mid(BASE + 32'h8, 32'h0BADF00D);
        do_req(BASE + 32'h8, 32'h0, 4'hF, 1'b0, 2'd3, 1'b0);

        do_b2b(BASE + 32'(4 * DEPTH - 4), 4, 2'd2);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                3:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                4:       a = 32'($urandom_range(0, int'(BASE) - 1)) & ~32'h3;
                default: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
            endcase
            do_req(a, $urandom, 4'($urandom), 1'($urandom), TS'($urandom),
                   ($urandom_range(0, 5) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
